// File: rtl/rf_wb_if.sv
// rf_wb_if: write-back arbiter bus bundle.
//   Pipeline side : wb_valid, wb_rd, wb_data
//   Coprocessor   : cp_valid, cp_rd, cp_data -> cp_ready
//   Register file : rf_reg_write, rf_rd, rf_wdata
//   Decode status : pending_mask, cp_empty
// master = producer/consumer side (pipeline, coprocessor, RF, decode),
// slave  = the arbiter itself.
interface rf_wb_if;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        cp_valid;
    logic [4:0]  cp_rd;
    logic [31:0] cp_data;
    logic        cp_ready;
    logic        rf_reg_write;
    logic [4:0]  rf_rd;
    logic [31:0] rf_wdata;
    logic [31:0] pending_mask;
    logic        cp_empty;

    modport master (
        output wb_valid, wb_rd, wb_data, cp_valid, cp_rd, cp_data,
        input  cp_ready, rf_reg_write, rf_rd, rf_wdata, pending_mask, cp_empty
    );

    modport slave (
        input  wb_valid, wb_rd, wb_data, cp_valid, cp_rd, cp_data,
        output cp_ready, rf_reg_write, rf_rd, rf_wdata, pending_mask, cp_empty
    );
endinterface

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: merges the in-order pipeline write-back stream with the
// buffered coprocessor result stream into one registered RF write port.
//   clk, rst_n : core clock, async active-low reset
//   bus        : rf_wb_if.slave (wb_*, cp_*, rf_*, pending_mask, cp_empty)
// Pipeline writes always win; FIFO heads drain in idle slots. Pipeline
// writes kill resident FIFO entries targeting the same register (WAW).

// One FIFO slot: {live, rd, data}. A write takes priority over pop/kill so
// an entry enqueued in the same cycle as a matching pipeline write survives.
module rf_wb_arbiter_slot (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_en,
    input  logic [4:0]  wr_rd,
    input  logic [31:0] wr_data,
    input  logic        pop_en,
    input  logic        kill_en,
    input  logic [4:0]  kill_rd,
    output logic        live,
    output logic [4:0]  rd,
    output logic [31:0] data
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            live <= 1'b0;
            rd   <= 5'd0;
            data <= 32'd0;
        end else if (wr_en) begin
            live <= 1'b1;
            rd   <= wr_rd;
            data <= wr_data;
        end else if (pop_en || (kill_en && rd == kill_rd)) begin
            // Popped slots are cleared too so free slots never show up
            // in pending_mask.
            live <= 1'b0;
        end
    end
endmodule

module rf_wb_arbiter #(
    parameter int DEPTH = 4
) (
    input  logic    clk,
    input  logic    rst_n,
    rf_wb_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          full, empty;
    logic          wb_take, push, pop;

    logic [DEPTH-1:0]        slot_live;
    logic [DEPTH-1:0][4:0]   slot_rd;
    logic [DEPTH-1:0][31:0]  slot_data;
    logic [DEPTH-1:0]        slot_wr, slot_pop;
    logic [31:0]             mask;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    assign bus.cp_ready = !full;
    assign bus.cp_empty = empty;

    // Writes to x0 are no-ops on both streams: an x0 pipeline write leaves
    // the slot idle for draining, an x0 coprocessor result is acknowledged
    // but dropped.
    assign wb_take = bus.wb_valid && (bus.wb_rd != 5'd0);
    assign push    = bus.cp_valid && !full && (bus.cp_rd != 5'd0);
    assign pop     = !wb_take && !empty;

    always_comb begin
        slot_wr  = '0;
        slot_pop = '0;
        for (int i = 0; i < DEPTH; i++) begin
            slot_wr[i]  = push && (wr_ptr == PW'(i));
            slot_pop[i] = pop  && (rd_ptr == PW'(i));
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_slot
        rf_wb_arbiter_slot u_slot (
            .clk     (clk),
            .rst_n   (rst_n),
            .wr_en   (slot_wr[g]),
            .wr_rd   (bus.cp_rd),
            .wr_data (bus.cp_data),
            .pop_en  (slot_pop[g]),
            .kill_en (wb_take),
            .kill_rd (bus.wb_rd),
            .live    (slot_live[g]),
            .rd      (slot_rd[g]),
            .data    (slot_data[g])
        );
    end

    // Pointers wrap naturally at DEPTH (power of two). Push and pop in the
    // same cycle only happen with 0 < count < DEPTH, so slots never alias.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Registered RF port. rd/wdata hold when nothing is issued; a killed
    // head still loads its fields but with the write enable low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.rf_reg_write <= 1'b0;
            bus.rf_rd        <= 5'd0;
            bus.rf_wdata     <= 32'd0;
        end else if (wb_take) begin
            bus.rf_reg_write <= 1'b1;
            bus.rf_rd        <= bus.wb_rd;
            bus.rf_wdata     <= bus.wb_data;
        end else if (pop) begin
            bus.rf_reg_write <= slot_live[rd_ptr];
            bus.rf_rd        <= slot_rd[rd_ptr];
            bus.rf_wdata     <= slot_data[rd_ptr];
        end else begin
            bus.rf_reg_write <= 1'b0;
        end
    end

    always_comb begin
        mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (slot_live[i]) mask[slot_rd[i]] = 1'b1;
        end
        mask[0] = 1'b0;
    end

    assign bus.pending_mask = mask;
endmodule

// File: doc/rf_wb_arbiter.md
# rf_wb_arbiter

Write-back arbiter sitting directly upstream of the register-file write decoder. It merges the in-order pipeline write-back stream and the out-of-order image-coprocessor result stream into the single `rd` / `reg_write` / write-data port the register file consumes. Coprocessor results are buffered in a small FIFO and drained in pipeline idle slots. The block also keeps a pending-write mask so decode can stall reads of registers with outstanding coprocessor results.

## Interface
- `DEPTH`, 4 — coprocessor result FIFO entries; power of two, ≥2.
- `clk` in 1 — core clock; all state updates on the rising edge.
- `rst_n` in 1 — asynchronous, active-low reset.
- `wb_valid` in 1 — pipeline write-back request; always accepted (no back-pressure).
- `wb_rd` in 5 — pipeline destination register.
- `wb_data` in 32 — pipeline write data.
- `cp_valid` in 1 — coprocessor result valid.
- `cp_rd` in 5 — coprocessor destination register.
- `cp_data` in 32 — coprocessor result data.
- `cp_ready` out 1 — FIFO can accept an entry; equals `count != DEPTH`.
- `rf_reg_write` out 1 — registered write enable to the register file decoder.
- `rf_rd` out 5 — registered destination register.
- `rf_wdata` out 32 — registered write data.
- `pending_mask` out 32 — bit i is 1 iff a live FIFO entry targets register i; bit 0 is always 0.
- `cp_empty` out 1 — FIFO holds no entries (live or killed).

## Operation
- **FIFO.** Circular buffer of `DEPTH` entries, each holding {live, rd, data}. Read and write pointers are `log2(DEPTH)` bits and wrap naturally. `count` is `log2(DEPTH)+1` bits.
- **Enqueue.** Occurs when `cp_valid && cp_ready`.
  - `cp_rd == 0`: the handshake completes, but nothing is enqueued.
  - Otherwise the entry is written with live=1.
  - When full, `cp_ready` is 0 even if a pop happens in the same cycle. Full-cycle push/pop is not allowed.
- **Output-register priority,** evaluated every cycle:
  1. `wb_valid && wb_rd != 0`: load pipeline write, `rf_reg_write`=1.
  2. Otherwise, if FIFO is non-empty: pop the head. `rf_reg_write` = head.live, and `rf_rd`/`rf_wdata` = head fields. A killed head pops with `rf_reg_write`=0.
  3. Otherwise: `rf_reg_write`=0, and `rf_rd`/`rf_wdata` hold their previous values.
- **`wb_valid` with `wb_rd == 0`.** Treated as idle, so the FIFO may drain in that cycle.
- **WAW kill.** When a pipeline write to rd=r (r≠0) is accepted, every FIFO entry already resident with rd=r has live cleared in the same edge.
  - An entry enqueued in that same cycle with rd=r is NOT killed; it stays live.
  - An entry popped in that cycle is not possible, because the pipeline has priority.
- **`pending_mask`.** Combinational OR of one-hot(rd) over all live entries. It updates the cycle after enqueue, kill or pop.
- **Coprocessor back-pressure.** The coprocessor is never starved indefinitely only if the pipeline has idle slots; no fairness guarantee is provided.

## Timing
- **Reset (async assert, sync release).**
  - `rf_reg_write`=0, `rf_rd`=0, `rf_wdata`=0.
  - Pointers and count = 0, all live bits = 0.
  - Hence `pending_mask`=0, `cp_empty`=1, `cp_ready`=1.
  - Reset mid-operation discards all FIFO contents with no write issued.
- **Pipeline latency.** A `wb_valid` sampled at edge N appears on `rf_*` after edge N; the register file writes at edge N+1.
- **Coprocessor latency.** Enqueue at edge N; the earliest `rf_reg_write` for it is after edge N+1, given `wb_valid`=0 in cycle N+1. Minimum 2 edges to output.
- **Output timing.** `cp_ready`, `cp_empty` and `pending_mask` are combinational from state only, with no input-to-output paths. All `rf_*` outputs are registered.
- **Throughput.** One register-file write per cycle maximum. With the pipeline idle, the coprocessor sustains one result per cycle (push and pop in the same cycle, count unchanged).

## Test plan
- **Reset values.** Assert `rst_n`=0 mid-stream with 3 entries queued → all outputs immediately at reset values; after release, `cp_empty`=1 and no `rf_reg_write` pulse appears.
- **Pipeline priority.**
  - Stimulus: `wb_valid`=1 (`wb_rd`=5, `wb_data`=0xAAAA0001) for 3 cycles while `cp` pushes rd=7, data 0x77.
  - Expected: `rf_rd`=5 for 3 cycles; then `rf_rd`=7, `rf_wdata`=0x77 the first idle cycle. `pending_mask`=0x80 until that pop.
- **Full FIFO.**
  - Stimulus: hold `wb_valid`=1 and push DEPTH=4 entries (rd 1..4).
  - Expected: `cp_ready`=0 after the 4th; a 5th `cp_valid` is held off. After the pipeline goes idle, 4 writes appear in order rd 1,2,3,4, and `cp_ready` returns to 1 after the first pop. Pointer wrap is exercised by repeating 3 times.
- **WAW kill.**
  - Stimulus: queue rd=9 (data 0x1), then pipeline write rd=9 (data 0x2).
  - Expected: `pending_mask[9]` clears the next cycle; the head pop produces `rf_reg_write`=0; the final reg 9 value is 0x2. In a same-cycle variant (enqueue rd=9 while the pipeline writes rd=9), the queued entry stays live and writes 0x1 later.
- **x0 handling.** Drive `cp_rd`=0 and `wb_rd`=0 → no enqueue, `cp_ready` stays 1, no `rf_reg_write`; a queued entry drains during the `wb_rd`=0 cycle.
- **Streaming.** Pipeline idle, `cp_valid`=1 every cycle with rd 1..31 → one `rf_reg_write` per cycle after 2-cycle latency, count stays ≤1, data in order.
